// File: rtl/iterative_alu.sv
// Handshaked EX-stage ALU. Logic, add/sub, compare and shift ops finish in one
// cycle. MUL/MULHU (shift-add) and DIVU/REMU (restoring division) take WIDTH
// iteration cycles. A single 2*WIDTH product/remainder register is shared by
// both iterative units.
module iterative_alu #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = $clog2(WIDTH)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               flush,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   A,
    input  logic [WIDTH-1:0]   B,
    input  logic [SHAMT_W-1:0] shamt,
    input  logic [3:0]         ALU_operation,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   res,
    output logic               zero,
    output logic               carry,
    output logic               overflow,
    output logic               div_by_zero
);

    localparam logic [3:0] OP_AND   = 4'h0;
    localparam logic [3:0] OP_OR    = 4'h1;
    localparam logic [3:0] OP_ADD   = 4'h2;
    localparam logic [3:0] OP_XOR   = 4'h3;
    localparam logic [3:0] OP_NOR   = 4'h4;
    localparam logic [3:0] OP_SRL   = 4'h5;
    localparam logic [3:0] OP_SUB   = 4'h6;
    localparam logic [3:0] OP_SLTU  = 4'h7;
    localparam logic [3:0] OP_SLT   = 4'h8;
    localparam logic [3:0] OP_SLL   = 4'h9;
    localparam logic [3:0] OP_SRA   = 4'hA;
    localparam logic [3:0] OP_MUL   = 4'hB;
    localparam logic [3:0] OP_MULHU = 4'hC;
    localparam logic [3:0] OP_DIVU  = 4'hD;
    localparam logic [3:0] OP_REMU  = 4'hE;

    localparam logic [SHAMT_W-1:0] CNT_LAST = SHAMT_W'(WIDTH - 1);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t               state_reg, state_next;
    logic [3:0]           op_reg;
    logic [WIDTH-1:0]     mcand_reg;      // multiplicand (MUL) or divisor (DIV)
    logic [2*WIDTH-1:0]   prod_reg;       // {hi, lo}: product, or {remainder, quotient}
    logic [2*WIDTH-1:0]   prod_next;
    logic [SHAMT_W-1:0]   cnt_reg;
    logic [WIDTH-1:0]     res_reg;
    logic                 carry_reg;
    logic                 overflow_reg;
    logic                 dbz_reg;

    logic                 accept;
    logic                 accept_iter;
    logic                 accept_mul;
    logic                 accept_div;
    logic                 op_is_mul;
    logic                 cnt_last;

    logic [WIDTH:0]       sum_ext;
    logic [WIDTH-1:0]     diff;
    logic [WIDTH-1:0]     single_res;
    logic                 single_carry;
    logic                 single_ovf;

    logic [WIDTH:0]       mul_sum;
    logic [WIDTH:0]       div_shift;
    logic                 div_ge;
    logic [WIDTH-1:0]     div_trial;
    logic [WIDTH-1:0]     rem_next;
    logic [WIDTH-1:0]     iter_res;

    // flush suppresses an accept even when in_valid is high in IDLE
    assign in_ready    = (state_reg == IDLE);
    assign accept      = in_valid && in_ready && !flush;
    assign accept_mul  = (ALU_operation == OP_MUL)  || (ALU_operation == OP_MULHU);
    assign accept_div  = (ALU_operation == OP_DIVU) || (ALU_operation == OP_REMU);
    assign accept_iter = accept_mul || accept_div;
    assign op_is_mul   = (op_reg == OP_MUL) || (op_reg == OP_MULHU);
    assign cnt_last    = (cnt_reg == CNT_LAST);

    assign out_valid   = (state_reg == DONE);
    assign res         = res_reg;
    assign zero        = out_valid && (res_reg == '0);
    assign carry       = carry_reg;
    assign overflow    = overflow_reg;
    assign div_by_zero = dbz_reg;

    // Single-cycle result and flags straight from the input operands
    always_comb begin
        sum_ext      = {1'b0, A} + {1'b0, B};
        diff         = A - B;
        single_res   = '0;
        single_carry = 1'b0;
        single_ovf   = 1'b0;
        case (ALU_operation)
            OP_AND:  single_res = A & B;
            OP_OR:   single_res = A | B;
            OP_XOR:  single_res = A ^ B;
            OP_NOR:  single_res = ~(A | B);
            OP_ADD: begin
                single_res   = sum_ext[WIDTH-1:0];
                single_carry = sum_ext[WIDTH];
                single_ovf   = (A[WIDTH-1] == B[WIDTH-1]) && (sum_ext[WIDTH-1] != A[WIDTH-1]);
            end
            OP_SUB: begin
                single_res   = diff;
                single_carry = (A < B);
                single_ovf   = (A[WIDTH-1] != B[WIDTH-1]) && (diff[WIDTH-1] != A[WIDTH-1]);
            end
            OP_SLTU: single_res = {{(WIDTH-1){1'b0}}, (A < B)};
            OP_SLT:  single_res = {{(WIDTH-1){1'b0}}, ($signed(A) < $signed(B))};
            OP_SRL:  single_res = B >> shamt;
            OP_SLL:  single_res = B << shamt;
            OP_SRA:  single_res = $unsigned($signed(B) >>> shamt);
            default: single_res = '0;   // iterative ops and reserved opcode
        endcase
    end

    // One iteration step of the shift-add multiplier or restoring divider
    always_comb begin
        mul_sum   = {1'b0, prod_reg[2*WIDTH-1:WIDTH]}
                  + (prod_reg[0] ? {1'b0, mcand_reg} : {(WIDTH+1){1'b0}});
        div_shift = prod_reg[2*WIDTH-1:WIDTH-1];
        div_ge    = (div_shift >= {1'b0, mcand_reg});
        // when div_ge holds the difference is below the divisor, so WIDTH bits suffice
        div_trial = div_shift[WIDTH-1:0] - mcand_reg;
        rem_next  = div_ge ? div_trial : div_shift[WIDTH-1:0];
        if (op_is_mul) begin
            prod_next = {mul_sum, prod_reg[WIDTH-1:1]};
        end else begin
            prod_next = {rem_next, prod_reg[WIDTH-2:0], div_ge};
        end
        // MULHU and REMU read the high half, MUL and DIVU the low half
        if ((op_reg == OP_MULHU) || (op_reg == OP_REMU)) begin
            iter_res = prod_next[2*WIDTH-1:WIDTH];
        end else begin
            iter_res = prod_next[WIDTH-1:0];
        end
    end

    // Next-state logic; flush overrides every transition
    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: if (accept) state_next = accept_iter ? BUSY : DONE;
            BUSY: if (cnt_last) state_next = DONE;
            DONE: if (out_ready) state_next = IDLE;
            default: state_next = IDLE;
        endcase
        if (flush) begin
            state_next = IDLE;
        end
    end

    // State register
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    // Operand capture, iteration and result/flag registers
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            op_reg       <= '0;
            mcand_reg    <= '0;
            prod_reg     <= '0;
            cnt_reg      <= '0;
            res_reg      <= '0;
            carry_reg    <= 1'b0;
            overflow_reg <= 1'b0;
            dbz_reg      <= 1'b0;
        end else if (accept) begin
            op_reg       <= ALU_operation;
            cnt_reg      <= '0;
            mcand_reg    <= accept_mul ? A : B;
            prod_reg     <= {{WIDTH{1'b0}}, (accept_mul ? B : A)};
            res_reg      <= single_res;
            carry_reg    <= single_carry;
            overflow_reg <= single_ovf;
            dbz_reg      <= accept_div && (B == '0);
        end else if (state_reg == BUSY) begin
            prod_reg <= prod_next;
            cnt_reg  <= cnt_reg + 1'b1;
            if (cnt_last) begin
                res_reg <= iter_res;
            end
        end
    end

endmodule
